vram_arbiter_m: RTL and testbench

Shares the GPU's single-port VRAM between the CPU write path and the GPU render fetch. CPU writes decoded for the VRAM window are buffered in a small FIFO and drained into idle VRAM cycles. GPU reads always win unless the optional starvation guard forces a write slot. The block sits between the address-bus/VRAM-select logic and the VRAM macro inside the GPU, in the `clk_12_5875` domain.

---
 rtl/vram_arbiter_m.sv | 169 ++++++++++++++++
 tb/tb_vram_arbiter_m.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter_m.sv
// VRAM port arbiter: buffers CPU writes in a small FIFO and drains them into cycles the GPU fetch leaves idle.
// Optional starvation guard (forced write slot) is compiled in with `define VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter_m #(
    parameter int ADDR_W       = 12,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk_12_5875,
    input  logic                       rst,
    input  logic                       cpu_wr_req,
    input  logic [ADDR_W-1:0]          cpu_wr_addr,
    input  logic [7:0]                 cpu_wr_data,
    output logic                       cpu_wr_ready,
    input  logic                       gpu_rd_req,
    input  logic [ADDR_W-1:0]          gpu_rd_addr,
    output logic                       gpu_rd_gnt,
    output logic                       gpu_rd_valid,
    output logic [7:0]                 gpu_rd_data,
    output logic [ADDR_W-1:0]          vram_addr,
    output logic [7:0]                 vram_wdata,
    output logic                       vram_we,
    input  logic [7:0]                 vram_rdata,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = PW - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FORCE = 2'd3
    } state_e;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("vram_arbiter_m: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    logic [ADDR_W+7:0]   mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       level_q, level_d;
    logic                ready_q, ready_d;
    logic                overflow_q, overflow_d;
    logic [ADDR_W-1:0]   vram_addr_q, vram_addr_d;
    state_e              state_q, state_d;
    logic                push_s, pop_s, empty_s, force_s;
    logic [ADDR_W+7:0]   head_s;

    assign push_s  = cpu_wr_req && ready_q;
    assign empty_s = (level_q == PW'(0));
    assign head_s  = mem_q[rd_ptr_q[IW-1:0]];

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_q, starve_d;

    // Force a write slot when this cycle would be the STARVE_LIMIT-th consecutive denial.
    assign force_s = !empty_s && ((int'(starve_q) + 1) >= STARVE_LIMIT);

    always_comb begin
        starve_d = starve_q;
        if (empty_s || pop_s) begin
            starve_d = '0;
        end else if (int'(starve_q) < STARVE_LIMIT) begin
            starve_d = starve_q + CW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_s = 1'b0;
`endif

    // Next-state: the arbitration decision for the current cycle.
    always_comb begin
        state_d = ST_IDLE;
        if (force_s) begin
            state_d = ST_FORCE;
        end else if (gpu_rd_req) begin
            state_d = ST_READ;
        end else if (!empty_s) begin
            state_d = ST_WRITE;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Output decode of the current decision; vram_addr holds its last value when idle.
    always_comb begin
        gpu_rd_gnt  = 1'b0;
        vram_we     = 1'b0;
        vram_wdata  = 8'h00;
        vram_addr_d = vram_addr_q;
        pop_s       = 1'b0;
        case (state_d)
            ST_READ: begin
                gpu_rd_gnt  = 1'b1;
                vram_addr_d = gpu_rd_addr;
            end
            ST_WRITE, ST_FORCE: begin
                vram_we     = 1'b1;
                pop_s       = 1'b1;
                vram_addr_d = head_s[ADDR_W+7:8];
                vram_wdata  = head_s[7:0];
            end
            ST_IDLE: begin
                vram_addr_d = vram_addr_q;
            end
            default: begin
                vram_addr_d = vram_addr_q;
            end
        endcase
    end

    // FIFO bookkeeping; ready is derived from the next level so it reflects the level at cycle start.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(push_s);
        rd_ptr_d   = rd_ptr_q + PW'(pop_s);
        level_d    = level_q + PW'(push_s) - PW'(pop_s);
        ready_d    = (level_d != PW'(DEPTH));
        overflow_d = overflow_q | (cpu_wr_req & ~ready_q);
    end

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ready_q     <= 1'b1;
            overflow_q  <= 1'b0;
            vram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ready_q     <= ready_d;
            overflow_q  <= overflow_d;
            vram_addr_q <= vram_addr_d;
        end
    end

    // FIFO storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk_12_5875) begin
        if (push_s) begin
            mem_q[wr_ptr_q[IW-1:0]] <= {cpu_wr_addr, cpu_wr_data};
        end
    end

    assign cpu_wr_ready = ready_q;
    assign fifo_level   = level_q;
    assign overflow     = overflow_q;
    assign vram_addr    = vram_addr_d;
    assign gpu_rd_valid = (state_q == ST_READ);
    assign gpu_rd_data  = gpu_rd_valid ? vram_rdata : 8'h00;

endmodule

// File: tb/tb_vram_arbiter_m.sv
// Bench for vram_arbiter_m: table of per-cycle vectors plus directed sequences for starvation, wrap and reset.
module tb_vram_arbiter_m;

    logic        clk;
    logic        rst;
    logic        cpu_wr_req;
    logic [11:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_wr_ready;
    logic        gpu_rd_req;
    logic [11:0] gpu_rd_addr;
    logic        gpu_rd_gnt;
    logic        gpu_rd_valid;
    logic [7:0]  gpu_rd_data;
    logic [11:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic [7:0]  vram_rdata;
    logic [2:0]  fifo_level;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    vram_arbiter_m #(.ADDR_W(12), .DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk_12_5875 (clk),
        .rst         (rst),
        .cpu_wr_req  (cpu_wr_req),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_wr_ready(cpu_wr_ready),
        .gpu_rd_req  (gpu_rd_req),
        .gpu_rd_addr (gpu_rd_addr),
        .gpu_rd_gnt  (gpu_rd_gnt),
        .gpu_rd_valid(gpu_rd_valid),
        .gpu_rd_data (gpu_rd_data),
        .vram_addr   (vram_addr),
        .vram_wdata  (vram_wdata),
        .vram_we     (vram_we),
        .vram_rdata  (vram_rdata),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port VRAM model, read-first.
    logic [7:0] vmem [4096];
    always @(posedge clk) begin
        if (vram_we) vmem[vram_addr] <= vram_wdata;
        vram_rdata <= vmem[vram_addr];
    end

    typedef struct {
        logic        wr;  logic [11:0] wa; logic [7:0] wd;
        logic        rd;  logic [11:0] ra;
        logic        gnt; logic        we; logic [11:0] va; logic [7:0] vw;
        logic [2:0]  lv;  logic        rdy; logic ovf; logic vld; logic [7:0] rdat;
    } vec_t;

    function automatic vec_t mk(logic wr, logic [11:0] wa, logic [7:0] wd, logic rd, logic [11:0] ra,
                                logic gnt, logic we, logic [11:0] va, logic [7:0] vw, logic [2:0] lv,
                                logic rdy, logic ovf, logic vld, logic [7:0] rdat);
        vec_t v;
        v = '{wr, wa, wd, rd, ra, gnt, we, va, vw, lv, rdy, ovf, vld, rdat};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [11:0] wa, input logic [7:0] wd,
                         input logic rd, input logic [11:0] ra);
        cpu_wr_req  = wr;
        cpu_wr_addr = wa;
        cpu_wr_data = wd;
        gpu_rd_req  = rd;
        gpu_rd_addr = ra;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 12'h000, 8'h00, 1'b0, 12'h000);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t vt [22];
    logic [19:0] exp_q [$];

    initial begin
        vt[0]  = mk(1'b1, 12'h100, 8'h3C, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        vt[1]  = mk(1'b1, 12'h012, 8'hA5, 1'b0, 12'h000, 1'b0, 1'b1, 12'h100, 8'h3C, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00);
        vt[2]  = mk(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1, 12'h012, 8'hA5, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00);
        vt[3]  = mk(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 12'h012, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        vt[4]  = mk(1'b0, 12'h000, 8'h00, 1'b1, 12'h100, 1'b1, 1'b0, 12'h100, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        vt[5]  = mk(1'b0, 12'h000, 8'h00, 1'b1, 12'h100, 1'b1, 1'b0, 12'h100, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 8'h3C);
        vt[6]  = mk(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 12'h100, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 8'h3C);
        vt[7]  = mk(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 12'h100, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        vt[8]  = mk(1'b0, 12'h000, 8'h00, 1'b1, 12'h012, 1'b1, 1'b0, 12'h012, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        vt[9]  = mk(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 12'h012, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 8'hA5);
        vt[10] = mk(1'b1, 12'h200, 8'h10, 1'b1, 12'h100, 1'b1, 1'b0, 12'h100, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        vt[11] = mk(1'b1, 12'h201, 8'h11, 1'b1, 12'h100, 1'b1, 1'b0, 12'h100, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1, 8'h3C);
        vt[12] = mk(1'b1, 12'h202, 8'h12, 1'b1, 12'h100, 1'b1, 1'b0, 12'h100, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1, 8'h3C);
        vt[13] = mk(1'b1, 12'h203, 8'h13, 1'b1, 12'h100, 1'b1, 1'b0, 12'h100, 8'h00, 3'd3, 1'b1, 1'b0, 1'b1, 8'h3C);
        vt[14] = mk(1'b1, 12'h204, 8'h14, 1'b1, 12'h100, 1'b1, 1'b0, 12'h100, 8'h00, 3'd4, 1'b0, 1'b0, 1'b1, 8'h3C);
        vt[15] = mk(1'b0, 12'h000, 8'h00, 1'b1, 12'h100, 1'b1, 1'b0, 12'h100, 8'h00, 3'd4, 1'b0, 1'b1, 1'b1, 8'h3C);
        vt[16] = mk(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1, 12'h200, 8'h10, 3'd4, 1'b0, 1'b1, 1'b1, 8'h3C);
        vt[17] = mk(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1, 12'h201, 8'h11, 3'd3, 1'b1, 1'b1, 1'b0, 8'h00);
        vt[18] = mk(1'b1, 12'h300, 8'h77, 1'b0, 12'h000, 1'b0, 1'b1, 12'h202, 8'h12, 3'd2, 1'b1, 1'b1, 1'b0, 8'h00);
        vt[19] = mk(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1, 12'h203, 8'h13, 3'd2, 1'b1, 1'b1, 1'b0, 8'h00);
        vt[20] = mk(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1, 12'h300, 8'h77, 3'd1, 1'b1, 1'b1, 1'b0, 8'h00);
        vt[21] = mk(1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 12'h300, 8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00);

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset.ready", cpu_wr_ready, 1'b1);
        chk("reset.level", fifo_level, 3'd0);
        chk("reset.ovf", overflow, 1'b0);
        chk("reset.valid", gpu_rd_valid, 1'b0);
        chk("reset.rdata", gpu_rd_data, 8'h00);
        chk("reset.we", vram_we, 1'b0);
        chk("reset.addr", vram_addr, 12'h000);
        chk("reset.gnt", gpu_rd_gnt, 1'b0);
        next_cycle();

        // Table: writes, reads, fill/overflow, drain with simultaneous push/pop
        for (int i = 0; i < 22; i++) begin
            drive(vt[i].wr, vt[i].wa, vt[i].wd, vt[i].rd, vt[i].ra);
            @(negedge clk);
            chk($sformatf("row%0d.gnt", i), gpu_rd_gnt, vt[i].gnt);
            chk($sformatf("row%0d.we", i), vram_we, vt[i].we);
            chk($sformatf("row%0d.addr", i), vram_addr, vt[i].va);
            chk($sformatf("row%0d.level", i), fifo_level, vt[i].lv);
            chk($sformatf("row%0d.ready", i), cpu_wr_ready, vt[i].rdy);
            chk($sformatf("row%0d.ovf", i), overflow, vt[i].ovf);
            chk($sformatf("row%0d.valid", i), gpu_rd_valid, vt[i].vld);
            if (vt[i].we) chk($sformatf("row%0d.wdata", i), vram_wdata, vt[i].vw);
            if (vt[i].vld) chk($sformatf("row%0d.rdata", i), gpu_rd_data, vt[i].rdat);
            next_cycle();
        end

        // Reset mid-operation: 3 queued writes, a read in flight, overflow still set
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 12'h600 + 12'(i), 8'hE0 + 8'(i), 1'b1, 12'h100);
            next_cycle();
        end
        drive(1'b0, 12'h000, 8'h00, 1'b1, 12'h100);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 12'h000, 8'h00, 1'b0, 12'h000);
        @(negedge clk);
        chk("rst_mid.level", fifo_level, 3'd0);
        chk("rst_mid.valid", gpu_rd_valid, 1'b0);
        chk("rst_mid.ovf", overflow, 1'b0);
        chk("rst_mid.ready", cpu_wr_ready, 1'b1);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rst_mid.we%0d", k), vram_we, 1'b0);
            next_cycle();
            @(negedge clk);
        end
        next_cycle();

        // One write under continuous GPU fetch
        do_reset();
        drive(1'b1, 12'h555, 8'h5A, 1'b1, 12'h100);
        next_cycle();
        drive(1'b0, 12'h000, 8'h00, 1'b1, 12'h100);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
`ifdef VRAM_ARB_STARVE_GUARD_EN
            chk($sformatf("starve.we%0d", k), vram_we, (k == 8) ? 1'b1 : 1'b0);
            chk($sformatf("starve.gnt%0d", k), gpu_rd_gnt, (k == 8) ? 1'b0 : 1'b1);
            if (k == 8) chk("starve.addr", vram_addr, 12'h555);
            if (k == 8) chk("starve.wdata", vram_wdata, 8'h5A);
`else
            chk($sformatf("starve.we%0d", k), vram_we, 1'b0);
            chk($sformatf("starve.gnt%0d", k), gpu_rd_gnt, 1'b1);
`endif
            next_cycle();
        end
        @(negedge clk);
`ifdef VRAM_ARB_STARVE_GUARD_EN
        chk("starve.level", fifo_level, 3'd0);
`else
        chk("starve.level", fifo_level, 3'd1);
`endif
        next_cycle();

        // Pointer wrap: 20 writes with intermittent reads, order preserved into VRAM
        do_reset();
        begin
            int pushed;
            int seen;
            int c;
            logic [19:0] front;
            pushed = 0;
            seen = 0;
            c = 0;
            while (c < 100 && !(pushed == 20 && exp_q.size() == 0)) begin
                drive((pushed < 20) && (c % 2 == 0), 12'h400 + 12'(pushed), 8'(pushed * 7 + 1),
                      (c % 5) < 2, 12'h100);
                @(negedge clk);
                if (vram_we) begin
                    if (exp_q.size() == 0) begin
                        chk("wrap.spurious_we", vram_we, 1'b0);
                    end else begin
                        front = exp_q.pop_front();
                        chk($sformatf("wrap.write%0d", seen), {vram_addr, vram_wdata}, front);
                        seen++;
                    end
                end
                if (cpu_wr_req) begin
                    chk($sformatf("wrap.ready%0d", pushed), cpu_wr_ready, 1'b1);
                    if (cpu_wr_ready) begin
                        exp_q.push_back({cpu_wr_addr, cpu_wr_data});
                        pushed++;
                    end
                end
                next_cycle();
                c++;
            end
            chk("wrap.count", seen, 20);
            chk("wrap.pending", exp_q.size(), 0);
            drive(1'b0, 12'h000, 8'h00, 1'b0, 12'h000);
            @(negedge clk);
            chk("wrap.ovf", overflow, 1'b0);
            chk("wrap.level", fifo_level, 3'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
